// File: rtl/ac97_input_deframer_pkg.sv
// AC97 frame geometry shared by the receive deframer and the output generator.
package ac97_input_deframer_pkg;

  localparam int FRAME_LEN = 256;
  localparam int TAG_BITS  = 16;
  localparam int SLOT_BITS = 20;

  // Bit index of the last bit in a frame; the next sync rise must land here.
  localparam logic [7:0] B_LAST     = 8'(FRAME_LEN - 1);
  // Last bit of the tag slot.
  localparam logic [7:0] B_TAG_END  = 8'(TAG_BITS - 1);
  // First bit index where sync must already be low again (sync is 16 bits wide).
  localparam logic [7:0] B_SYNC_LOW = 8'(TAG_BITS - 1);

  // Tag bit carrying codec ready.
  localparam int TAG_READY_BIT = 15;

  // Last bit index of slot n (1..12).
  function automatic logic [7:0] slot_end(input int n);
    return 8'(TAG_BITS + SLOT_BITS * n - 1);
  endfunction

endpackage

// File: rtl/ac97_frame_counter.sv
// Frame alignment: sync-rise detect, bit counter, HUNT/RECV state, error detect.
//
//  state | meaning
//  HUNT  | not aligned, waiting for a sync rise
//  RECV  | inside a frame, bit_idx is the index of the bit sampled this edge
module ac97_frame_counter
  import ac97_input_deframer_pkg::*;
#(
  parameter bit SYNC_LEN_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  output logic [7:0] bit_idx,
  output logic       in_frame,
  output logic       frame_error
);

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  logic [0:0] state;
  logic       sync_prev;
  logic       sync_rise;
  logic       len_bad;

  assign sync_rise = sync & ~sync_prev;
  assign in_frame  = (state == ST_RECV);

  // Sync must stay high through bit 14 and stay low from bit 15 until the next frame.
  always_comb begin
    len_bad = 1'b0;
    if (SYNC_LEN_CHECK && state == ST_RECV) begin
      if (bit_idx < B_SYNC_LOW)
        len_bad = ~sync;
      else if (bit_idx != B_LAST)
        len_bad = sync;
    end
  end

  // A rise always restarts the frame, even when it also signals an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HUNT;
      bit_idx     <= '0;
      sync_prev   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      sync_prev   <= sync;
      frame_error <= 1'b0;
      if (sync_rise) begin
        if (state == ST_RECV && (bit_idx != B_LAST || len_bad))
          frame_error <= 1'b1;
        state   <= ST_RECV;
        bit_idx <= '0;
      end else if (state == ST_RECV) begin
        if (bit_idx == B_LAST || len_bad) begin
          frame_error <= 1'b1;
          state       <= ST_HUNT;
          bit_idx     <= '0;
        end else begin
          bit_idx <= bit_idx + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ac97_input_deframer.sv
// AC97 receive deframer: tag, slot 1/2 register status and slot 3/4 PCM capture.
module ac97_input_deframer
  import ac97_input_deframer_pkg::*;
#(
  parameter int PCM_WIDTH      = 16,
  parameter bit SYNC_LEN_CHECK = 1'b1
) (
  input  logic                 ac97_bitclk,
  input  logic                 reset,
  input  logic                 ac97_sync,
  input  logic                 ac97_sdata_in,
  output logic                 codec_ready,
  output logic [11:0]          slot_valid,
  output logic [9:0]           slot_request,
  output logic [6:0]           status_addr,
  output logic [15:0]          status_data,
  output logic                 status_valid,
  output logic [PCM_WIDTH-1:0] pcm_left,
  output logic [PCM_WIDTH-1:0] pcm_right,
  output logic                 pcm_valid,
  output logic                 frame_error,
  output logic                 in_frame
);

  localparam logic [7:0] B_SLOT1_END = slot_end(1);
  localparam logic [7:0] B_SLOT2_END = slot_end(2);
  localparam logic [7:0] B_SLOT3_END = slot_end(3);
  localparam logic [7:0] B_SLOT4_END = slot_end(4);

  logic [7:0]           bit_idx;
  // Bit 19 of the window is never needed after the shift, so only 19 bits are stored.
  logic [SLOT_BITS-2:0] shift_q;
  logic [SLOT_BITS-1:0] shift_d;
  logic [16:0]          slot1_pend;   // slot 1 bits 18:2
  logic [PCM_WIDTH-1:0] slot3_pend;
  logic                 status_ok;
  logic                 pcm_ok;

  ac97_frame_counter #(
    .SYNC_LEN_CHECK(SYNC_LEN_CHECK)
  ) u_frame_counter (
    .clk        (ac97_bitclk),
    .rst        (reset),
    .sync       (ac97_sync),
    .bit_idx    (bit_idx),
    .in_frame   (in_frame),
    .frame_error(frame_error)
  );

  // Window including the bit sampled this edge, so commits see the complete slot.
  assign shift_d   = {shift_q, ac97_sdata_in};
  // slot_valid[12-n] flags slot n.
  assign status_ok = codec_ready & slot_valid[11] & slot_valid[10];
  assign pcm_ok    = codec_ready & slot_valid[9] & slot_valid[8];

  // Shift while in a frame and commit each slot on the edge that samples its last bit.
  always_ff @(posedge ac97_bitclk or posedge reset) begin
    if (reset) begin
      shift_q      <= '0;
      slot1_pend   <= '0;
      slot3_pend   <= '0;
      codec_ready  <= 1'b0;
      slot_valid   <= '0;
      slot_request <= '0;
      status_addr  <= '0;
      status_data  <= '0;
      status_valid <= 1'b0;
      pcm_left     <= '0;
      pcm_right    <= '0;
      pcm_valid    <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      pcm_valid    <= 1'b0;
      if (in_frame) begin
        shift_q <= shift_d[SLOT_BITS-2:0];
        case (bit_idx)
          B_TAG_END: begin
            codec_ready <= shift_d[TAG_READY_BIT];
            slot_valid  <= shift_d[14:3];
          end
          B_SLOT1_END: slot1_pend <= shift_d[18:2];
          B_SLOT2_END: begin
            if (status_ok) begin
              status_addr  <= slot1_pend[16:10];
              slot_request <= slot1_pend[9:0];
              status_data  <= shift_d[19:4];
              status_valid <= 1'b1;
            end
          end
          B_SLOT3_END: slot3_pend <= shift_d[SLOT_BITS-1 -: PCM_WIDTH];
          B_SLOT4_END: begin
            if (pcm_ok) begin
              pcm_left  <= slot3_pend;
              pcm_right <= shift_d[SLOT_BITS-1 -: PCM_WIDTH];
              pcm_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ac97_input_deframer.sv
// Self-checking bench for ac97_input_deframer: frame-level model, per-cycle compare.
module tb_ac97_input_deframer;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          sync;
  logic          sdata;
  logic          codec_ready;
  logic [11:0]   slot_valid;
  logic [9:0]    slot_request;
  logic [6:0]    status_addr;
  logic [15:0]   status_data;
  logic          status_valid;
  logic [PW-1:0] pcm_left;
  logic [PW-1:0] pcm_right;
  logic          pcm_valid;
  logic          frame_error;
  logic          in_frame;

  always #5 clk = ~clk;

  ac97_input_deframer #(.PCM_WIDTH(PW), .SYNC_LEN_CHECK(1'b1)) dut (
    .ac97_bitclk  (clk),
    .reset        (reset),
    .ac97_sync    (sync),
    .ac97_sdata_in(sdata),
    .codec_ready  (codec_ready),
    .slot_valid   (slot_valid),
    .slot_request (slot_request),
    .status_addr  (status_addr),
    .status_data  (status_data),
    .status_valid (status_valid),
    .pcm_left     (pcm_left),
    .pcm_right    (pcm_right),
    .pcm_valid    (pcm_valid),
    .frame_error  (frame_error),
    .in_frame     (in_frame)
  );

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;
  bit need_start = 1'b1;

  // Expected outputs after the most recent clock edge.
  logic          m_codec_ready;
  logic [11:0]   m_slot_valid;
  logic [9:0]    m_slot_request;
  logic [6:0]    m_status_addr;
  logic [15:0]   m_status_data;
  logic          m_status_valid;
  logic [PW-1:0] m_pcm_left;
  logic [PW-1:0] m_pcm_right;
  logic          m_pcm_valid;
  logic          m_frame_error;
  logic          m_in_frame;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_codec_ready  = 1'b0;
    m_slot_valid   = '0;
    m_slot_request = '0;
    m_status_addr  = '0;
    m_status_data  = '0;
    m_status_valid = 1'b0;
    m_pcm_left     = '0;
    m_pcm_right    = '0;
    m_pcm_valid    = 1'b0;
    m_frame_error  = 1'b0;
    m_in_frame     = 1'b0;
  endtask

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("codec_ready",  32'(codec_ready),  32'(m_codec_ready));
      check("slot_valid",   32'(slot_valid),   32'(m_slot_valid));
      check("slot_request", 32'(slot_request), 32'(m_slot_request));
      check("status_addr",  32'(status_addr),  32'(m_status_addr));
      check("status_data",  32'(status_data),  32'(m_status_data));
      check("status_valid", 32'(status_valid), 32'(m_status_valid));
      check("pcm_left",     32'(pcm_left),     32'(m_pcm_left));
      check("pcm_right",    32'(pcm_right),    32'(m_pcm_right));
      check("pcm_valid",    32'(pcm_valid),    32'(m_pcm_valid));
      check("frame_error",  32'(frame_error),  32'(m_frame_error));
      check("in_frame",     32'(in_frame),     32'(m_in_frame));
    end
  end

  // One bit period: drive on the falling edge, let the rising edge sample it.
  task automatic step(input logic s, input logic d);
    @(negedge clk);
    sync  = s;
    sdata = d;
    @(posedge clk);
    #1;
    m_status_valid = 1'b0;
    m_pcm_valid    = 1'b0;
    m_frame_error  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    sync  = 1'b0;
    model_zero();
    #1;
    check("async_rst_codec_ready", 32'(codec_ready), 32'd0);
    check("async_rst_slot_valid",  32'(slot_valid),  32'd0);
    check("async_rst_status_addr", 32'(status_addr), 32'd0);
    check("async_rst_status_data", 32'(status_data), 32'd0);
    check("async_rst_pcm_left",    32'(pcm_left),    32'd0);
    check("async_rst_in_frame",    32'(in_frame),    32'd0);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Idle a little with sync low, then raise sync to open a frame from HUNT.
  task automatic start_frame();
    repeat (1 + $urandom_range(0, 3)) step(1'b0, 1'($urandom));
    step(1'b1, 1'($urandom));
    m_in_frame = 1'b1;
  endtask

  // mode 0: good frame, next frame follows; 1: sync missing at bit 255;
  // 2: early sync rise at end_b; 3: reset before bit end_b; 4: bad sync width at end_b (<=15).
  task automatic run_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                           input logic [19:0] s3, input logic [19:0] s4,
                           input int mode, input int end_b);
    logic [19:0]  sl [1:12];
    logic [255:0] st;
    logic         s;
    sl[1] = s1; sl[2] = s2; sl[3] = s3; sl[4] = s4;
    for (int n = 5; n <= 12; n++) sl[n] = 20'($urandom);
    for (int b = 0; b < 16; b++) st[b] = tag[15-b];
    for (int n = 1; n <= 12; n++)
      for (int k = 0; k < 20; k++) st[16 + 20*(n-1) + k] = sl[n][19-k];
    for (int b = 0; b < 256; b++) begin
      if (mode == 3 && b == end_b) begin
        do_reset();
        need_start = 1'b1;
        return;
      end
      s = (b <= 14) || (b == 255 && mode == 0);
      if ((mode == 2 || mode == 4) && b == end_b) s = ~s;
      step(s, st[b]);
      if (b == 15) begin
        m_codec_ready = tag[15];
        m_slot_valid  = tag[14:3];
      end
      if (b == 55 && tag[15] && tag[14] && tag[13]) begin
        m_status_addr  = s1[18:12];
        m_slot_request = s1[11:2];
        m_status_data  = s2[19:4];
        m_status_valid = 1'b1;
      end
      if (b == 95 && tag[15] && tag[12] && tag[11]) begin
        m_pcm_left  = s3[19 -: PW];
        m_pcm_right = s4[19 -: PW];
        m_pcm_valid = 1'b1;
      end
      if ((mode == 2 || mode == 4) && b == end_b) begin
        m_frame_error = 1'b1;
        m_in_frame    = (mode == 2);
        need_start    = (mode == 4);
        return;
      end
      if (b == 255 && mode != 0) begin
        m_frame_error = 1'b1;
        m_in_frame    = 1'b0;
      end
    end
    need_start = (mode != 0);
  endtask

  task automatic frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                       input logic [19:0] s3, input logic [19:0] s4,
                       input int mode, input int end_b);
    if (need_start) start_frame();
    run_frame(tag, s1, s2, s3, s4, mode, end_b);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] tag;
    int          mode;
    int          end_b;
    reset = 1'b0;
    sync  = 1'b0;
    sdata = 1'b0;
    model_zero();
    #1 reset = 1'b1;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Codec ready, slots 1..4 valid: register status plus PCM.
    frame(16'hF800, {1'b0, 7'h26, 10'h155, 2'b00}, {16'h000F, 4'h0}, 20'h11111, 20'h22222, 0, 0);
    check("t1_status_addr",  32'(status_addr),  32'h26);
    check("t1_status_data",  32'(status_data),  32'h000F);
    check("t1_slot_request", 32'(slot_request), 32'h155);
    check("t1_model_addr",   32'(m_status_addr), 32'h26);

    // Slots 3/4 only: PCM truncated to 16 MSBs, status held.
    frame(16'h9800, 20'hFFFFF, 20'hFFFFF, 20'hABCDE, 20'h12345, 0, 0);
    check("t2_pcm_left",    32'(pcm_left),    32'hABCD);
    check("t2_pcm_right",   32'(pcm_right),   32'h1234);
    check("t2_status_addr", 32'(status_addr), 32'h26);
    check("t2_model_pcm_l", 32'(m_pcm_left),  32'hABCD);

    // Codec not ready: everything held except the tag outputs.
    frame(16'h0000, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 0, 0);
    check("t3_codec_ready", 32'(codec_ready), 32'd0);
    check("t3_pcm_left",    32'(pcm_left),    32'hABCD);

    // Early sync rise at bit 100, then a good frame.
    frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 2, 100);
    frame(16'hE000, {1'b0, 7'h11, 10'h0AA, 2'b11}, {16'hBEEF, 4'hA}, 20'h0, 20'h0, 0, 0);
    check("t4_status_addr", 32'(status_addr), 32'h11);
    check("t4_status_data", 32'(status_data), 32'hBEEF);

    // Sync missing at bit 255, idle in HUNT, then recover.
    frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 1, 0);
    check("t5_in_frame", 32'(in_frame), 32'd0);
    repeat (10) step(1'b0, 1'($urandom));
    frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 0, 0);

    // Reset in the middle of a frame, then a full new frame.
    frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 3, 60);
    frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 0, 0);

    // Sync width violations: dropped early, and held one bit too long.
    frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 4, 10);
    frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 4, 15);
    // Error coinciding with the status commit edge.
    frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 2, 55);

    for (int i = 0; i < 20; i++) begin
      tag = 16'($urandom);
      for (int j = 11; j <= 15; j++) tag[j] = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       begin mode = 1; end_b = 0; end
        1:       begin mode = 2; end_b = $urandom_range(16, 254); end
        2:       begin mode = 3; end_b = $urandom_range(1, 255); end
        3:       begin mode = 4; end_b = $urandom_range(0, 15); end
        default: begin mode = 0; end_b = 0; end
      endcase
      frame(tag, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), mode, end_b);
    end
    frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 1, 0);
    repeat (3) step(1'b0, 1'b0);

    @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
